// File: rtl/wb_arb_pkg.sv
// Shared types and grant encodings for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } state_t;

  typedef enum logic {
    RR_M0 = 1'b0,
    RR_M1 = 1'b1
  } master_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_arbiter_2m_if.sv
// One Wishbone link; master drives the request side, slave answers with ack/read data.
interface wb_arbiter_2m_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [ADDR_WIDTH-1:0]     adr;
  logic [DATA_WIDTH-1:0]     wdat;
  logic [DATA_WIDTH/8-1:0]   sel;
  logic                      ack;
  logic [DATA_WIDTH-1:0]     rdat;

  modport master (output cyc, stb, we, adr, wdat, sel, input  ack, rdat);
  modport slave  (input  cyc, stb, we, adr, wdat, sel, output ack, rdat);
endinterface

// File: rtl/wb_arb_mux.sv
// Combinational routing: granted master onto the slave link, ack back to the owner only.
module wb_arb_mux
  import wb_arb_pkg::*;
(
  input  logic [1:0]         grant_i,
  wb_arbiter_2m_if.slave     m0,
  wb_arbiter_2m_if.slave     m1,
  wb_arbiter_2m_if.master    s
);
  logic sel_m0;
  logic sel_m1;

  assign sel_m0 = (grant_i == GRANT_M0);
  assign sel_m1 = (grant_i == GRANT_M1);

  assign s.cyc  = sel_m0 ? m0.cyc  : sel_m1 ? m1.cyc  : 1'b0;
  assign s.stb  = sel_m0 ? m0.stb  : sel_m1 ? m1.stb  : 1'b0;
  assign s.we   = sel_m0 ? m0.we   : sel_m1 ? m1.we   : 1'b0;
  assign s.adr  = sel_m0 ? m0.adr  : sel_m1 ? m1.adr  : '0;
  assign s.wdat = sel_m0 ? m0.wdat : sel_m1 ? m1.wdat : '0;
  assign s.sel  = sel_m0 ? m0.sel  : sel_m1 ? m1.sel  : '0;

  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0.ack  = s.ack & sel_m0;
  assign m1.ack  = s.ack & sel_m1;
  assign m0.rdat = s.rdat;
  assign m1.rdat = s.rdat;
endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter: grant held for a whole cycle, round-robin on ties.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wbm0_cyc_i,
  input  logic                    wbm0_stb_i,
  input  logic                    wbm0_we_i,
  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wbm0_sel_i,
  output logic                    wbm0_ack_o,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  input  logic                    wbm1_cyc_i,
  input  logic                    wbm1_stb_i,
  input  logic                    wbm1_we_i,
  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wbm1_sel_i,
  output logic                    wbm1_ack_o,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  output logic                    wbs_cyc_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_we_o,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic [DATA_WIDTH/8-1:0] wbs_sel_o,
  input  logic                    wbs_ack_i,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [1:0]              grant_o
);

  wb_arbiter_2m_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) m0_bus ();
  wb_arbiter_2m_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) m1_bus ();
  wb_arbiter_2m_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) s_bus ();

  assign m0_bus.cyc  = wbm0_cyc_i;
  assign m0_bus.stb  = wbm0_stb_i;
  assign m0_bus.we   = wbm0_we_i;
  assign m0_bus.adr  = wbm0_adr_i;
  assign m0_bus.wdat = wbm0_dat_i;
  assign m0_bus.sel  = wbm0_sel_i;
  assign wbm0_ack_o  = m0_bus.ack;
  assign wbm0_dat_o  = m0_bus.rdat;

  assign m1_bus.cyc  = wbm1_cyc_i;
  assign m1_bus.stb  = wbm1_stb_i;
  assign m1_bus.we   = wbm1_we_i;
  assign m1_bus.adr  = wbm1_adr_i;
  assign m1_bus.wdat = wbm1_dat_i;
  assign m1_bus.sel  = wbm1_sel_i;
  assign wbm1_ack_o  = m1_bus.ack;
  assign wbm1_dat_o  = m1_bus.rdat;

  assign wbs_cyc_o   = s_bus.cyc;
  assign wbs_stb_o   = s_bus.stb;
  assign wbs_we_o    = s_bus.we;
  assign wbs_adr_o   = s_bus.adr;
  assign wbs_dat_o   = s_bus.wdat;
  assign wbs_sel_o   = s_bus.sel;
  assign s_bus.ack   = wbs_ack_i;
  assign s_bus.rdat  = wbs_dat_i;

  state_t     state_q, state_d;
  master_t    rr_last_q, rr_last_d;
  logic [1:0] grant_q, grant_d;
  logic       hold;

  // A release falls straight through to arbitration, so ownership can pass without an idle cycle.
  always_comb begin
    state_d   = IDLE;
    grant_d   = GRANT_NONE;
    rr_last_d = rr_last_q;
    hold      = (state_q == GNT_M0 && wbm0_cyc_i) || (state_q == GNT_M1 && wbm1_cyc_i);
    if (hold) begin
      state_d = state_q;
      grant_d = grant_q;
    end else if (wbm0_cyc_i && (!wbm1_cyc_i || rr_last_q == RR_M1)) begin
      state_d   = GNT_M0;
      grant_d   = GRANT_M0;
      rr_last_d = RR_M0;
    end else if (wbm1_cyc_i) begin
      state_d   = GNT_M1;
      grant_d   = GRANT_M1;
      rr_last_d = RR_M1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= GRANT_NONE;
      rr_last_q <= RR_M0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign grant_o = grant_q;

  wb_arb_mux u_mux (
    .grant_i (grant_q),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .s       (s_bus)
  );

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench: directed scenarios plus randomized traffic against an ownership model.
module tb_wb_arbiter_2m;
  logic clk = 1'b0;
  logic reset;

  wb_arbiter_2m_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
  wb_arbiter_2m_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
  wb_arbiter_2m_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

  logic        wbm0_ack_o, wbm1_ack_o;
  logic [31:0] wbm0_dat_o, wbm1_dat_o;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [31:0] wbs_adr_o, wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .wbm0_cyc_i (m0_if.cyc),
    .wbm0_stb_i (m0_if.stb),
    .wbm0_we_i  (m0_if.we),
    .wbm0_adr_i (m0_if.adr),
    .wbm0_dat_i (m0_if.wdat),
    .wbm0_sel_i (m0_if.sel),
    .wbm0_ack_o (wbm0_ack_o),
    .wbm0_dat_o (wbm0_dat_o),
    .wbm1_cyc_i (m1_if.cyc),
    .wbm1_stb_i (m1_if.stb),
    .wbm1_we_i  (m1_if.we),
    .wbm1_adr_i (m1_if.adr),
    .wbm1_dat_i (m1_if.wdat),
    .wbm1_sel_i (m1_if.sel),
    .wbm1_ack_o (wbm1_ack_o),
    .wbm1_dat_o (wbm1_dat_o),
    .wbs_cyc_o  (wbs_cyc_o),
    .wbs_stb_o  (wbs_stb_o),
    .wbs_we_o   (wbs_we_o),
    .wbs_adr_o  (wbs_adr_o),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_sel_o  (wbs_sel_o),
    .wbs_ack_i  (s_if.ack),
    .wbs_dat_i  (s_if.rdat),
    .grant_o    (grant_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner is -1 (nobody), 0 or 1; last is the most recent winner.
  int owner = -1;
  int last  = 0;
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      owner    = -1;
      last     = 0;
      model_ok = 1'b1;
    end else begin
      bit owner_keeps;
      owner_keeps = (owner == 0 && m0_if.cyc) || (owner == 1 && m1_if.cyc);
      if (!owner_keeps) begin
        if (m0_if.cyc && m1_if.cyc) owner = 1 - last;
        else if (m0_if.cyc)         owner = 0;
        else if (m1_if.cyc)         owner = 1;
        else                        owner = -1;
        if (owner >= 0) last = owner;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      logic [31:0] e_adr, e_dat;
      logic [3:0]  e_sel;
      logic [2:0]  e_ctl;
      e_adr = '0; e_dat = '0; e_sel = '0; e_ctl = '0;
      if (owner == 0) begin
        e_adr = m0_if.adr; e_dat = m0_if.wdat; e_sel = m0_if.sel;
        e_ctl = {m0_if.cyc, m0_if.stb, m0_if.we};
      end else if (owner == 1) begin
        e_adr = m1_if.adr; e_dat = m1_if.wdat; e_sel = m1_if.sel;
        e_ctl = {m1_if.cyc, m1_if.stb, m1_if.we};
      end
      chk("m_grant", 64'(grant_o), 64'((owner < 0) ? 0 : (1 << owner)));
      chk("m_ctl",   64'({wbs_cyc_o, wbs_stb_o, wbs_we_o}), 64'(e_ctl));
      chk("m_adr",   64'(wbs_adr_o), 64'(e_adr));
      chk("m_wdat",  64'(wbs_dat_o), 64'(e_dat));
      chk("m_sel",   64'(wbs_sel_o), 64'(e_sel));
      chk("m_ack0",  64'(wbm0_ack_o), 64'(s_if.ack && owner == 0));
      chk("m_ack1",  64'(wbm1_ack_o), 64'(s_if.ack && owner == 1));
      chk("m_rdat0", 64'(wbm0_dat_o), 64'(s_if.rdat));
      chk("m_rdat1", 64'(wbm1_dat_o), 64'(s_if.rdat));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_quiet();
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.adr = '0; m0_if.wdat = '0; m0_if.sel = '0;
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.adr = '0; m1_if.wdat = '0; m1_if.sel = '0;
    s_if.ack = 0; s_if.rdat = '0;
  endtask

  initial begin
    all_quiet();
    reset = 1;
    tick(); tick();
    reset = 0;

    // Idle after reset, stray ack must not leak.
    repeat (3) begin
      @(negedge clk);
      chk("idle_grant", 64'(grant_o), 64'(2'b00));
      chk("idle_ctl", 64'({wbs_cyc_o, wbs_stb_o, wbs_we_o}), 64'(3'b000));
      chk("idle_adr", 64'(wbs_adr_o), 64'(0));
      tick();
    end
    s_if.ack = 1; s_if.rdat = 32'h55;
    @(negedge clk);
    chk("stray_ack", 64'({wbm1_ack_o, wbm0_ack_o}), 64'(2'b00));
    tick();
    s_if.ack = 0;

    // M0 alone reads 0x8000_0000.
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h8000_0000; m0_if.sel = 4'hf;
    @(negedge clk);
    chk("t2_req_cyc", 64'(wbs_cyc_o), 64'(0));
    tick();
    @(negedge clk);
    chk("t2_cyc_rise", 64'(wbs_cyc_o), 64'(1));
    chk("t2_grant", 64'(grant_o), 64'(2'b01));
    chk("t2_adr", 64'(wbs_adr_o), 64'(32'h8000_0000));
    tick();
    s_if.ack = 1; s_if.rdat = 32'h0000_0013;
    @(negedge clk);
    chk("t2_ack0", 64'(wbm0_ack_o), 64'(1));
    chk("t2_dat0", 64'(wbm0_dat_o), 64'(32'h13));
    chk("t2_ack1", 64'(wbm1_ack_o), 64'(0));
    tick();
    s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
    @(negedge clk);
    chk("t2_grant_until_edge", 64'(grant_o), 64'(2'b01));
    tick();
    @(negedge clk);
    chk("t2_released", 64'(grant_o), 64'(2'b00));

    // Tie right after reset: M1 first, then M0 with no idle cycle.
    reset = 1;
    tick();
    reset = 0;
    m0_if.cyc = 1; m0_if.stb = 1; m1_if.cyc = 1; m1_if.stb = 1;
    tick();
    @(negedge clk);
    chk("t3_m1_first", 64'(grant_o), 64'(2'b10));
    tick();
    s_if.ack = 1;
    @(negedge clk);
    chk("t3_ack", 64'({wbm1_ack_o, wbm0_ack_o}), 64'(2'b10));
    tick();
    s_if.ack = 0; m1_if.cyc = 0; m1_if.stb = 0;
    tick();
    @(negedge clk);
    chk("t3_handover", 64'(grant_o), 64'(2'b01));
    tick();
    m0_if.cyc = 0; m0_if.stb = 0;
    tick();

    // M1 write while M0 waits.
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.we = 1; m1_if.sel = 4'b0011;
    m1_if.adr = 32'h8000_0100; m1_if.wdat = 32'hDEAD_BEEF;
    tick();
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h0000_1234; m0_if.wdat = 32'h1111_2222;
    @(negedge clk);
    chk("t4_grant", 64'(grant_o), 64'(2'b10));
    chk("t4_ctl", 64'({wbs_cyc_o, wbs_stb_o, wbs_we_o}), 64'(3'b111));
    chk("t4_adr", 64'(wbs_adr_o), 64'(32'h8000_0100));
    chk("t4_dat", 64'(wbs_dat_o), 64'(32'hDEAD_BEEF));
    chk("t4_sel", 64'(wbs_sel_o), 64'(4'b0011));
    tick();
    s_if.ack = 1;
    @(negedge clk);
    chk("t4_no_ack0", 64'(wbm0_ack_o), 64'(0));
    chk("t4_ack1", 64'(wbm1_ack_o), 64'(1));
    tick();
    s_if.ack = 0; m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0;
    tick();
    @(negedge clk);
    chk("t4_m0_gets_bus", 64'(grant_o), 64'(2'b01));

    // M0 keeps cyc across a stb gap while M1 requests.
    tick();
    m0_if.stb = 0; m1_if.cyc = 1; m1_if.stb = 1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_hold", 64'(grant_o), 64'(2'b01));
      chk("t5_stb_gap", 64'(wbs_stb_o), 64'(0));
      tick();
    end
    m0_if.stb = 1;
    @(negedge clk);
    chk("t5_beat2", 64'({grant_o, wbs_stb_o}), 64'(3'b011));
    tick();
    m0_if.cyc = 0; m0_if.stb = 0;
    tick();
    @(negedge clk);
    chk("t5_switch", 64'(grant_o), 64'(2'b10));

    // Reset during GNT_M1 with the ack landing just after the edge.
    reset = 1;
    tick();
    s_if.ack = 1;
    @(negedge clk);
    chk("t6_cyc_drop", 64'(wbs_cyc_o), 64'(0));
    chk("t6_no_ack1", 64'(wbm1_ack_o), 64'(0));
    chk("t6_grant", 64'(grant_o), 64'(2'b00));
    tick();
    reset = 0; s_if.ack = 0; m0_if.cyc = 1; m0_if.stb = 1;
    tick();
    @(negedge clk);
    chk("t6_m1_favoured", 64'(grant_o), 64'(2'b10));
    tick();
    all_quiet();
    tick();

    // Randomized traffic; the compare process checks every cycle.
    for (int unsigned n = 0; n < 3000; n++) begin
      if (m0_if.cyc) begin if ($urandom_range(5) == 0) m0_if.cyc = 0; end
      else if ($urandom_range(3) == 0) m0_if.cyc = 1;
      if (m1_if.cyc) begin if ($urandom_range(5) == 0) m1_if.cyc = 0; end
      else if ($urandom_range(3) == 0) m1_if.cyc = 1;
      m0_if.stb = m0_if.cyc & 1'($urandom_range(1));
      m1_if.stb = m1_if.cyc & 1'($urandom_range(1));
      m0_if.we = 1'($urandom_range(1)); m1_if.we = 1'($urandom_range(1));
      m0_if.adr = $urandom(); m1_if.adr = $urandom();
      m0_if.wdat = $urandom(); m1_if.wdat = $urandom();
      m0_if.sel = 4'($urandom_range(15)); m1_if.sel = 4'($urandom_range(15));
      s_if.ack = ($urandom_range(2) == 0);
      s_if.rdat = $urandom();
      reset = ($urandom_range(199) == 0);
      tick();
    end
    reset = 0;
    all_quiet();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
